// File: rtl/calc_pkg.sv
// Shared constants for the calculator control path: state encoding and datapath width.
package calc_pkg;

    localparam int CALC_WIDTH = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT_B = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Operand-collecting states are the only ones that take input bytes.
    function automatic logic calc_accepts_input(input logic [1:0] st);
        return (st == ST_IDLE) || (st == ST_WAIT_B);
    endfunction

endpackage

// File: rtl/math_subtractor_8bit.sv
// 8-bit unsigned subtractor: diff = a - b - bin (mod 256), bout set when the true result is negative.
module math_subtractor_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic [7:0] diff,
    output logic       bout
);

    logic [8:0] full;

    // The ninth bit of a zero-extended subtraction is the borrow-out.
    assign full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    assign diff = full[7:0];
    assign bout = full[8];

endmodule

// File: rtl/calc_sub_sequencer.sv
// Operand/result sequencer for the 8-bit subtract path.
// Optional CALC_SUB_SEQ_CHAIN_EN: an accepted non-underflow result becomes the next A.
module calc_sub_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_borrow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_diff,
    output logic             res_error,
    output logic             busy
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             bin_q, bin_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_diff_q, res_diff_d;
    logic             res_error_q, res_error_d;

    logic [WIDTH-1:0] sub_diff;
    logic             sub_bout;

    math_subtractor_8bit u_sub (
        .a    (a_q),
        .b    (b_q),
        .bin  (bin_q),
        .diff (sub_diff),
        .bout (sub_bout)
    );

    assign in_ready  = calc_accepts_input(state_q);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = res_valid_q;
    assign res_diff  = res_diff_q;
    assign res_error = res_error_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        bin_d       = bin_q;
        res_valid_d = res_valid_q;
        res_diff_d  = res_diff_q;
        res_error_d = res_error_q;

        // Abort wins over any handshake; the last result value is left visible.
        if (clear) begin
            state_d     = ST_IDLE;
            res_valid_d = 1'b0;
            a_d         = '0;
            b_d         = '0;
            bin_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_d     = in_data;
                        state_d = ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (in_valid) begin
                        b_d     = in_data;
                        bin_d   = in_borrow;
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_diff_d  = sub_diff;
                    res_error_d = sub_bout;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
                default: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
`ifdef CALC_SUB_SEQ_CHAIN_EN
                        if (!res_error_q) begin
                            a_d     = res_diff_q;
                            state_d = ST_WAIT_B;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            bin_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_diff_q  <= '0;
            res_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            bin_q       <= bin_d;
            res_valid_q <= res_valid_d;
            res_diff_q  <= res_diff_d;
            res_error_q <= res_error_d;
        end
    end

endmodule

// File: tb/tb_calc_sub_sequencer.sv
// Directed bench for calc_sub_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_calc_sub_sequencer;

`ifdef CALC_SUB_SEQ_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_borrow;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_diff;
    logic       res_error;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    calc_sub_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_borrow (in_borrow),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_diff  (res_diff),
        .res_error (res_error),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A then B, then check EXEC (no result yet) and DONE (result visible).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] exp_diff, input logic exp_err);
        @(negedge clk);
        in_valid = 1'b1; in_data = a; in_borrow = 1'b0;
        @(negedge clk);
        chk("a_taken_busy", busy, 1);
        in_data = b; in_borrow = bin;
        @(negedge clk);
        in_valid = 1'b0;
        chk("exec_res_valid", res_valid, 0);
        chk("exec_in_ready", in_ready, 0);
        @(negedge clk);
        chk("done_res_valid", res_valid, 1);
        chk("done_diff", res_diff, exp_diff);
        chk("done_error", res_error, exp_err);
    endtask

    // Consume the result; in chain builds a clean result parks in WAIT_B, so clear it away.
    task automatic accept(input logic err);
        logic exp_busy;
        exp_busy = CHAIN && !err;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("acc_res_valid", res_valid, 0);
        chk("acc_busy", busy, exp_busy);
        if (exp_busy) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            chk("acc_clr_busy", busy, 0);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_borrow = 1'b0; res_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_diff", res_diff, 8'h00);
        chk("rst_error", res_error, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h0F, 8'h05, 1'b0, 8'h0A, 1'b0);
        accept(1'b0);
        run_op(8'hAA, 8'h55, 1'b1, 8'h54, 1'b0);
        accept(1'b0);

        // Async reset while in EXEC: outputs drop before the next rising edge.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h40;
        @(negedge clk);
        in_data = 8'h10;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_diff", res_diff, 8'h54);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", res_valid, 0);
        chk("async_rst_diff", res_diff, 8'h00);
        chk("async_rst_busy", busy, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", res_valid, 0);
        chk("post_rst_busy", busy, 0);

        run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
        accept(1'b1);
        run_op(8'h81, 8'h81, 1'b0, 8'h00, 1'b0);
        accept(1'b0);

        // Consumer stalls in DONE while input bytes are offered.
        run_op(8'h30, 8'h01, 1'b0, 8'h2F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; in_data = 8'hC0 + 8'(i); in_borrow = 1'b1;
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_diff", res_diff, 8'h2F);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; in_borrow = 1'b0;
        accept(1'b0);

        // clear in WAIT_B beats the B handshake.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        in_data = 8'h33; clear = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_res_valid", res_valid, 0);
        chk("clr_keeps_diff", res_diff, 8'h2F);
        run_op(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
        accept(1'b1);

`ifdef CALC_SUB_SEQ_CHAIN_EN
        // Running subtraction: 0x0F-0x05=0x0A, -0x03=0x07, -0x09 underflows to 0xFE.
        run_op(8'h0F, 8'h05, 1'b0, 8'h0A, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("chain_wait_b", in_ready, 1);
        chk("chain_busy", busy, 1);
        in_valid = 1'b1; in_data = 8'h03; in_borrow = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("chain2_diff", res_diff, 8'h07);
        chk("chain2_err", res_error, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h09;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("chain3_diff", res_diff, 8'hFE);
        chk("chain3_err", res_error, 1);
        accept(1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
